// File: rtl/ss_display_ctrl.sv
// Multiplexed seven-segment display controller with hex/decimal (double dabble) loading.
// Optional macro SS_LZ_BLANK_EN blanks leading zero digits.
module ss_display_ctrl #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] value,
  input  logic              value_valid,
  input  logic              mode,
  output logic              value_ready,
  output logic              busy,
  output logic              ovf,
  output logic [DIGITS-1:0] ss_sel,
  output logic [6:0]        no_encoded
);

  localparam int unsigned BcdW  = 4 * DIGITS;
  localparam int unsigned HexW  = (DATA_W < BcdW) ? DATA_W : BcdW;
  localparam int unsigned RefW  = $clog2(REFRESH_DIV);
  localparam int unsigned ScanW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW  = $clog2(DATA_W);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StConv = 1'b1;

  localparam logic [6:0] SegDash = 7'b0111111;
  localparam logic [6:0] SegBlank = 7'b1111111;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              conv_ovf_q, conv_ovf_d;
  logic [BcdW-1:0]   disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic [RefW-1:0]   ref_q, ref_d;
  logic [ScanW-1:0]  scan_q, scan_d;
  logic [DIGITS-1:0] ss_sel_q, ss_sel_d;
  logic [6:0]        seg_q, seg_d;

  logic [BcdW-1:0]   hex_ext;
  logic [BcdW-1:0]   bcd_adj;
  logic [BcdW-1:0]   bcd_shift;
  logic              bcd_carry;
  logic [3:0]        cur_digit;
  logic              lz_blank;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    unique case (d)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    hex_ext = '0;
    hex_ext[HexW-1:0] = value[HexW-1:0];
  end

  // One double-dabble step: add 3 to any digit >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_carry = bcd_adj[BcdW-1];
    bcd_shift = {bcd_adj[BcdW-2:0], sh_q[DATA_W-1]};
  end

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    conv_ovf_d = conv_ovf_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    ref_d      = ref_q + RefW'(1);
    scan_d     = scan_q;

    if (ref_q == RefW'(REFRESH_DIV - 1)) begin
      ref_d  = '0;
      scan_d = (scan_q == ScanW'(DIGITS - 1)) ? '0 : scan_q + ScanW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (value_valid) begin
          if (mode) begin
            state_d    = StConv;
            sh_d       = value;
            bcd_d      = '0;
            cnt_d      = '0;
            conv_ovf_d = 1'b0;
          end else begin
            disp_d = hex_ext;
            ovf_d  = 1'b0;
          end
        end
      end
      StConv: begin
        sh_d       = sh_q << 1;
        bcd_d      = bcd_shift;
        conv_ovf_d = conv_ovf_q | bcd_carry;
        cnt_d      = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DATA_W - 1)) begin
          state_d = StIdle;
          disp_d  = bcd_shift;
          ovf_d   = conv_ovf_q | bcd_carry;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from next-state so select and glyph land on the same edge.
  always_comb begin
    cur_digit = disp_d[{scan_d, 2'b00} +: 4];
`ifdef SS_LZ_BLANK_EN
    lz_blank = (scan_d != '0) && ((disp_d >> {scan_d, 2'b00}) == '0);
`else
    lz_blank = 1'b0;
`endif
    if (ovf_d)         seg_d = SegDash;
    else if (lz_blank) seg_d = SegBlank;
    else               seg_d = glyph(cur_digit);
    ss_sel_d = ~(DIGITS'(1) << scan_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      sh_q       <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      conv_ovf_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      ref_q      <= '0;
      scan_q     <= '0;
      ss_sel_q   <= ~DIGITS'(1);
      seg_q      <= 7'b1000000;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      conv_ovf_q <= conv_ovf_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      ref_q      <= ref_d;
      scan_q     <= scan_d;
      ss_sel_q   <= ss_sel_d;
      seg_q      <= seg_d;
    end
  end

  assign value_ready = (state_q == StIdle);
  assign busy        = (state_q == StConv);
  assign ovf         = ovf_q;
  assign ss_sel      = ss_sel_q;
  assign no_encoded  = seg_q;

endmodule

// File: doc/ss_display_ctrl.md
SS_DISPLAY_CTRL -- requirements
Module: ss_display_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 8, number of multiplexed seven-segment digits (1..8).
REQ-002 SHALL have parameter DATA_W, default 32, width of the value to display (4..32).
REQ-003 SHALL have parameter REFRESH_DIV, default 1000, clock cycles each digit is held (>=2).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port value  input  DATA_W  unsigned number to display.
REQ-007 SHALL have port value_valid  input  1  request to load value.
REQ-008 SHALL have port mode  input  1  0 = hexadecimal, 1 = decimal; sampled with value.
REQ-009 SHALL have port value_ready  output  1  block can accept a value.
REQ-010 SHALL have port busy  output  1  decimal conversion in progress.
REQ-011 SHALL have port ovf  output  1  last decimal value exceeded DIGITS decimal digits.
REQ-012 SHALL have port ss_sel  output  DIGITS  digit enable, one-cold, active-low.
REQ-013 SHALL have port no_encoded  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-014 SHALL implement FSM states IDLE and CONV; value_ready = (state==IDLE); busy = (state==CONV).
REQ-015 SHALL accept a value only when value_valid && value_ready; value_valid while not ready is ignored, not queued.
REQ-016 Hex accept: SHALL stay in IDLE, update display nibbles from value[4*DIGITS-1:0] (zero-extended if DATA_W < 4*DIGITS) on the next edge, clear ovf; latency 1 cycle.
REQ-017 Decimal accept: SHALL enter CONV and run shift-add-3 (double dabble), one bit per cycle, for exactly DATA_W cycles, then return to IDLE and update display and ovf on that same edge; latency DATA_W+1 cycles from the accept edge.
REQ-018 During CONV, display SHALL keep showing the previous value; no partial BCD is ever displayed.
REQ-019 ovf SHALL be set when any 1 shifts out of the top BCD digit during conversion; on ovf every digit SHALL show dash (7'b0111111).
REQ-020 value_valid asserted in the cycle CONV completes SHALL NOT be accepted; it is accepted the following cycle if still asserted.
REQ-021 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the scan index SHALL advance 0..DIGITS-1 and wrap to 0.
REQ-022 ss_sel SHALL drive bit [scan index] low and all other bits high; no_encoded SHALL show that digit's glyph in the same cycle (registered together, no skew).
REQ-023 Glyphs (active-low gfedcba): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110; blank=1111111.
REQ-024 Value loading SHALL NOT disturb the refresh counter or scan index.

Reset
REQ-025 While rst==0 at a rising edge: state IDLE, conversion aborted, display digits 0, ovf 0, refresh counter 0, scan index 0.
REQ-026 Reset outputs: value_ready=1, busy=0, ovf=0, ss_sel = all ones except bit0=0, no_encoded=7'b1000000.

Configuration
REQ-027 Macro SS_LZ_BLANK_EN: when defined, digits above the most significant nonzero digit SHALL show blank (1111111), digit 0 always shown, ovf dashes never blanked; when undefined, all digits SHALL show their glyph including leading zeros.

Verification (DIGITS=4, DATA_W=16, REFRESH_DIV=4)
REQ-028 Hold rst=0 two cycles -> value_ready=1, busy=0, ovf=0, ss_sel=1110, no_encoded=1000000; reset asserted mid-CONV returns to these values next edge.
REQ-029 Scan, no load -> ss_sel sequence 1110,1101,1011,0111,1110, each held exactly 4 cycles.
REQ-030 Hex 0x1A3F -> next edge digit3=1111001, digit2=0001000, digit1=0110000, digit0=0001110; ready stays 1.
REQ-031 Decimal 1234 -> busy=1/ready=0 for 16 cycles, valid pulses meanwhile ignored; digits 1,2,3,4 after 17 cycles; ovf=0.
REQ-032 Decimal 12345 -> ovf=1, all digits 0111111; subsequent hex 0x0000 clears ovf.
REQ-033 SS_LZ_BLANK_EN defined, decimal 7 -> digits 3..1=1111111, digit0=1111000; undefined -> digits 3..1=1000000.
